// File: rtl/x_delay_line_pkg.sv
// x_delay_line_pkg
//   Shared types and defaults for the delay-line measurement controller.
//   state_t : controller FSM states
//   DL_DW   : default tap word width
//   DL_CW   : default tap count width ($clog2(DL_DW)+1)
package x_delay_line_pkg;

  localparam int unsigned DL_DW = 32;
  localparam int unsigned DL_CW = 6;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/x_delay_line_popcnt.sv
// x_delay_line_popcnt
//   Combinational matching-bit counter: number of bits of data equal to data[0].
//   Bit 0 is the polarity reference, so a thermometer word of either polarity
//   yields the same count. Result range is 1..DW.
//   Ports:
//     data  in  DW  captured tap word
//     count out CW  number of bits equal to data[0]
module x_delay_line_popcnt #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 6
) (
  input  logic [DW-1:0] data,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      count = count + CW'(data[i] ~^ data[0]);
    end
  end

endmodule

// File: rtl/x_delay_line_ctrl.sv
// x_delay_line_ctrl
//   Measurement sequencer for the 32-tap delay line. On i_req it launches
//   2**NSAMP_LOG2 edges (one o_start pulse each), waits SETTLE cycles for the
//   toggle plus 2-stage resync, converts each captured tap word to a tap count,
//   accumulates and returns sum/average over a valid/ready handshake.
//   Optional feature macro: X_DL_CTRL_MINMAX_EN (per-sample min/max tracking).
//   Ports:
//     i_clk      in   1               clock
//     i_rst      in   1               asynchronous active-high reset
//     i_req      in   1               start measurement (sampled in IDLE only)
//     o_busy     out  1               high in every state except IDLE
//     o_start    out  1               one-cycle launch pulse to the delay line
//     i_dl_data  in   DW              resynced tap word from the delay line
//     o_valid    out  1               result valid, held until accepted
//     i_ready    in   1               result accepted when o_valid & i_ready
//     o_sum      out  CW+NSAMP_LOG2   sum of sample counts
//     o_avg      out  CW              o_sum >> NSAMP_LOG2
//     o_min      out  CW              min sample count (0 without the macro)
//     o_max      out  CW              max sample count (0 without the macro)
module x_delay_line_ctrl
  import x_delay_line_pkg::*;
#(
  parameter  int unsigned DW         = DL_DW,
  parameter  int unsigned NSAMP_LOG2 = 3,
  parameter  int unsigned SETTLE     = 3,
  localparam int unsigned CW         = $clog2(DW) + 1,
  localparam int unsigned AW         = CW + NSAMP_LOG2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  output logic          o_busy,
  output logic          o_start,
  input  logic [DW-1:0] i_dl_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW-1:0] o_sum,
  output logic [CW-1:0] o_avg,
  output logic [CW-1:0] o_min,
  output logic [CW-1:0] o_max
);

  localparam int unsigned WW = $clog2(SETTLE + 1);

  state_t                state;
  logic [NSAMP_LOG2-1:0] scnt;
  logic [WW-1:0]         wcnt;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         acc_nxt;
  logic [CW-1:0]         tap;
  logic                  capture;
  logic                  last;

  x_delay_line_popcnt #(
    .DW (DW),
    .CW (CW)
  ) u_popcnt (
    .data  (i_dl_data),
    .count (tap)
  );

  // The final sample is folded in combinationally so the published sum
  // includes it on the same edge that enters DONE.
  assign acc_nxt = acc + AW'(tap);
  assign capture = (state == CAPTURE);
  assign last    = (scnt == '1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      scnt    <= '0;
      wcnt    <= '0;
      acc     <= '0;
      o_busy  <= 1'b0;
      o_start <= 1'b0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_avg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            state   <= LAUNCH;
            o_start <= 1'b1;
            o_busy  <= 1'b1;
            acc     <= '0;
            scnt    <= '0;
          end
        end
        LAUNCH: begin
          state   <= WAIT;
          o_start <= 1'b0;
          wcnt    <= '0;
        end
        WAIT: begin
          if (wcnt == WW'(SETTLE - 1)) begin
            state <= CAPTURE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        CAPTURE: begin
          acc  <= acc_nxt;
          scnt <= scnt + NSAMP_LOG2'(1);
          if (last) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_sum   <= acc_nxt;
            o_avg   <= acc_nxt[AW-1:NSAMP_LOG2];
          end else begin
            state   <= LAUNCH;
            o_start <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_start <= 1'b0;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef X_DL_CTRL_MINMAX_EN
  logic [CW-1:0] run_min;
  logic [CW-1:0] run_max;
  logic [CW-1:0] min_nxt;
  logic [CW-1:0] max_nxt;

  // First sample of a measurement loads both trackers.
  always_comb begin
    min_nxt = run_min;
    max_nxt = run_max;
    if (scnt == '0) begin
      min_nxt = tap;
      max_nxt = tap;
    end else begin
      if (tap < run_min) min_nxt = tap;
      if (tap > run_max) max_nxt = tap;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_min <= '0;
      run_max <= '0;
      o_min   <= '0;
      o_max   <= '0;
    end else if (capture) begin
      run_min <= min_nxt;
      run_max <= max_nxt;
      if (last) begin
        o_min <= min_nxt;
        o_max <= max_nxt;
      end
    end
  end
`else
  assign o_min = '0;
  assign o_max = '0;
`endif

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
module tb_x_delay_line_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic          ready = 1'b0;
  logic          busy;
  logic          start;
  logic          valid;
  logic [DW-1:0] dl_data;
  logic [AW-1:0] sum;
  logic [CW-1:0] avg;
  logic [CW-1:0] mn;
  logic [CW-1:0] mx;

  int n_checks = 0;
  int n_fail   = 0;

  // Delay-line model: source flop toggles on a launch, word built from the
  // programmed edge depth, then two resync stages.
  logic          model_clr = 1'b0;
  logic [5:0]    depth [8];
  logic          src = 1'b0;
  logic [DW-1:0] word = '0;
  logic [DW-1:0] s1 = '0;
  logic [DW-1:0] s2 = '0;
  logic [2:0]    idx = '0;
  int            n_start = 0;
  int            gap_err = 0;
  int            cyc_all = 0;
  int            last_start = 0;

  assign dl_data = s2;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] therm(input logic s, input logic [5:0] d);
    logic [DW-1:0] w;
    for (int i = 0; i < 32; i++) w[i] = (i <= int'(d)) ? s : ~s;
    return w;
  endfunction

  always @(posedge clk) begin
    cyc_all <= cyc_all + 1;
    if (model_clr) begin
      idx     <= '0;
      n_start <= 0;
      gap_err <= 0;
    end else if (start) begin
      src  <= ~src;
      word <= therm(~src, depth[idx]);
      idx  <= idx + 3'd1;
      if (n_start != 0 && (cyc_all - last_start) != 5) gap_err <= gap_err + 1;
      n_start    <= n_start + 1;
      last_start <= cyc_all;
    end
    s1 <= word;
    s2 <= s1;
  end

  x_delay_line_ctrl #(
    .DW         (32),
    .NSAMP_LOG2 (3),
    .SETTLE     (3)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .o_busy    (busy),
    .o_start   (start),
    .i_dl_data (dl_data),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_sum     (sum),
    .o_avg     (avg),
    .o_min     (mn),
    .o_max     (mx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_depth_all(input logic [5:0] d);
    for (int i = 0; i < 8; i++) depth[i] = d;
  endtask

  // Starts a measurement and waits for o_valid. Cycle count includes the
  // edge that samples i_req, so o_valid is first seen at count 41.
  task automatic run_meas(output int cycles);
    req       = 1'b1;
    model_clr = 1'b1;
    @(negedge clk);
    req       = 1'b0;
    model_clr = 1'b0;
    cycles    = 1;
    while (!valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    logic stable;
    logic [AW-1:0] held_sum;

    set_depth_all(6'd10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_avg", 32'(avg), 0);
    chk("rst_min", 32'(mn), 0);
    chk("rst_max", 32'(mx), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: depth 10 every sample -> 11 taps each
    req       = 1'b1;
    model_clr = 1'b1;
    @(negedge clk);
    req       = 1'b0;
    model_clr = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    cyc = 1;
    while (!valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t1_latency", 32'(cyc), 41);
    chk("t1_nstart", 32'(n_start), 8);
    chk("t1_gap", 32'(gap_err), 0);
    chk("t1_sum", 32'(sum), 88);
    chk("t1_avg", 32'(avg), 11);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("t1_idle", 32'(busy), 0);

    // 2: depth 20, polarity alternates with each launch -> 21 taps each
    set_depth_all(6'd20);
    ready = 1'b1;  // ready without valid is ignored
    @(negedge clk);
    ready = 1'b0;
    run_meas(cyc);
    chk("t2_latency", 32'(cyc), 41);
    chk("t2_sum", 32'(sum), 168);
    chk("t2_avg", 32'(avg), 21);

    // 3: hold in DONE with ready low and req pulses
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req = i[0];
      @(negedge clk);
      if (!valid || sum !== 9'd168 || !busy) stable = 1'b0;
    end
    chk("t3_stable", 32'(stable), 1);
    chk("t3_nstart", 32'(n_start), 8);
    req   = 1'b1;  // request in the accept cycle is ignored
    ready = 1'b1;
    @(negedge clk);
    req   = 1'b0;
    ready = 1'b0;
    chk("t3_valid_drop", 32'(valid), 0);
    chk("t3_busy_drop", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t3_still_idle", 32'(busy), 0);
    chk("t3_sum_held", 32'(sum), 168);
    chk("t3_avg_held", 32'(avg), 21);

    // 4: reset during the 4th WAIT
    set_depth_all(6'd10);
    req       = 1'b1;
    model_clr = 1'b1;
    @(negedge clk);
    req       = 1'b0;
    model_clr = 1'b0;
    repeat (16) @(negedge clk);
    chk("t4_busy_pre", 32'(busy), 1);
    chk("t4_nstart_pre", 32'(n_start), 4);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_start", 32'(start), 0);
    chk("t4_rst_valid", 32'(valid), 0);
    chk("t4_rst_sum", 32'(sum), 0);
    chk("t4_rst_avg", 32'(avg), 0);
    repeat (3) @(negedge clk);
    chk("t4_no_pulse", 32'(n_start), 4);
    rst = 1'b0;
    @(negedge clk);
    run_meas(cyc);
    chk("t4_latency", 32'(cyc), 41);
    chk("t4_nstart", 32'(n_start), 8);
    chk("t4_sum", 32'(sum), 88);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;

    // 5: all-equal words -> 32 taps each
    set_depth_all(6'd31);
    run_meas(cyc);
    chk("t5_sum", 32'(sum), 256);
    chk("t5_avg", 32'(avg), 32);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;

    // 6: counts 5,9,3,9,7,7,7,7
    depth[0] = 6'd4; depth[1] = 6'd8; depth[2] = 6'd2; depth[3] = 6'd8;
    depth[4] = 6'd6; depth[5] = 6'd6; depth[6] = 6'd6; depth[7] = 6'd6;
    run_meas(cyc);
    chk("t6_sum", 32'(sum), 54);
    chk("t6_avg", 32'(avg), 6);
`ifdef X_DL_CTRL_MINMAX_EN
    chk("t6_min", 32'(mn), 3);
    chk("t6_max", 32'(mx), 9);
`else
    chk("t6_min", 32'(mn), 0);
    chk("t6_max", 32'(mx), 0);
`endif
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("t6_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
